// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with a 2-entry elastic (main + skid) buffer,
// sideband tag, flush and a saturating illegal-instruction counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned PRESHIFT = 1,
  parameter int unsigned TAG_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fmt,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag,
  output logic [15:0]      o_illegal_cnt
);

  localparam logic [2:0] FmtI     = 3'd0;
  localparam logic [2:0] FmtShamt = 3'd1;
  localparam logic [2:0] FmtS     = 3'd2;
  localparam logic [2:0] FmtB     = 3'd3;
  localparam logic [2:0] FmtU     = 3'd4;
  localparam logic [2:0] FmtJ     = 3'd5;
  localparam logic [2:0] FmtNone  = 3'd6;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpReg32  = 7'b0111011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] imm64;
  logic [63:0] b_off;
  logic [63:0] j_off;
  entry_t      dec;

  entry_t      main_q, main_d, skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        ready_q, ready_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_acc, out_xfer;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];

  // Offsets always built as 64-bit sign-extended values; sliced to XLEN at the end.
  assign b_off = {{51{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                  i_instr[11:8], 1'b0};
  assign j_off = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                  i_instr[30:21], 1'b0};

  // Combinational decode of the incoming instruction word.
  always_comb begin
    imm64   = '0;
    dec.fmt = FmtNone;
    dec.ill = 1'b0;
    dec.tag = i_tag;
    case (opcode)
      OpImm, OpImm32: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.fmt = FmtShamt;
          // RV64 shift-immediates take a 6-bit shamt; W-ops and RV32 take 5 bits.
          if (XLEN == 64 && opcode == OpImm) imm64 = {58'b0, i_instr[25:20]};
          else                               imm64 = {59'b0, i_instr[24:20]};
        end else begin
          dec.fmt = FmtI;
          imm64   = {{52{i_instr[31]}}, i_instr[31:20]};
        end
      end
      OpLoad, OpJalr, OpFence: begin
        dec.fmt = FmtI;
        imm64   = {{52{i_instr[31]}}, i_instr[31:20]};
      end
      OpStore: begin
        dec.fmt = FmtS;
        imm64   = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OpBranch: begin
        dec.fmt = FmtB;
        imm64   = (PRESHIFT != 0) ? b_off : {b_off[63], b_off[63:1]};
      end
      OpJal: begin
        dec.fmt = FmtJ;
        imm64   = (PRESHIFT != 0) ? j_off : {j_off[63], j_off[63:1]};
      end
      OpLui, OpAuipc: begin
        dec.fmt = FmtU;
        imm64   = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
      end
      OpReg, OpReg32, OpSystem: begin
        dec.fmt = FmtNone;
      end
      default: begin
        dec.fmt = FmtNone;
        dec.ill = 1'b1;
      end
    endcase
    dec.imm = imm64[XLEN-1:0];
  end

  // o_ready mirrors "skid empty", so an accepted input always has a free slot.
  assign in_acc   = i_valid & ready_q & ~i_flush;
  assign out_xfer = main_valid_q & i_ready;

  // Buffer steering, ready and counter next-state.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (i_flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_acc;
        if (in_acc) main_d = dec;
      end
    end else if (in_acc) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
    if (in_acc && dec.ill && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = main_valid_q;
  assign o_imm         = main_q.imm;
  assign o_fmt         = main_q.fmt;
  assign o_illegal     = main_q.ill;
  assign o_tag         = main_q.tag;
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (PRESHIFT=1 and PRESHIFT=0 instances).
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] instr;
  logic [7:0]  tag;
  logic        flush;
  logic        dn_ready;

  logic        ready1, valid1, ill1;
  logic [63:0] imm1;
  logic [2:0]  fmt1;
  logic [7:0]  tag1;
  logic [15:0] cnt1;

  logic        ready0, valid0, ill0;
  logic [63:0] imm0;
  logic [2:0]  fmt0;
  logic [7:0]  tag0;
  logic [15:0] cnt0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .PRESHIFT(1), .TAG_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready1), .i_instr(instr),
    .i_tag(tag), .i_flush(flush), .o_valid(valid1), .i_ready(dn_ready), .o_imm(imm1),
    .o_fmt(fmt1), .o_illegal(ill1), .o_tag(tag1), .o_illegal_cnt(cnt1)
  );

  imm_gen_pipe #(.XLEN(64), .PRESHIFT(0), .TAG_W(8)) dut_ps0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready0), .i_instr(instr),
    .i_tag(tag), .i_flush(flush), .o_valid(valid0), .i_ready(dn_ready), .o_imm(imm0),
    .o_fmt(fmt0), .o_illegal(ill0), .o_tag(tag0), .o_illegal_cnt(cnt0)
  );

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  localparam int N = 13;
  logic [31:0] v_instr [N] = '{
    32'hFFF00093, 32'h43F0D093, 32'h43F0D09B, 32'h800000B7, 32'hFE000EE3,
    32'hFFDFF06F, 32'hFE112C23, 32'h8000C083, 32'h002081B3, 32'h00000000,
    32'h00000001, 32'h00001017, 32'h00000863};
  logic [63:0] v_imm1 [N] = '{
    64'hFFFFFFFFFFFFFFFF, 64'h3F, 64'h1F, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
    64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFF800, 64'h0, 64'h0,
    64'h0, 64'h1000, 64'h10};
  logic [63:0] v_imm0 [N] = '{
    64'hFFFFFFFFFFFFFFFF, 64'h3F, 64'h1F, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFE,
    64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFF800, 64'h0, 64'h0,
    64'h0, 64'h1000, 64'h8};
  logic [2:0] v_fmt [N] = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd3, 3'd5, 3'd2, 3'd0, 3'd6, 3'd6,
                             3'd6, 3'd4, 3'd3};
  logic       v_ill [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b1; valid = 1'b0; instr = '0; tag = '0; flush = 1'b0; dn_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_valid", valid1, 0);
    check_val("rst_ready", ready1, 1);
    check_val("rst_imm", imm1, 0);
    check_val("rst_fmt", fmt1, 0);
    check_val("rst_tag", tag1, 0);
    check_val("rst_illegal", ill1, 0);
    check_val("rst_cnt", cnt1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream, i_ready=1: vector i-1 observed while vector i is offered.
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_val($sformatf("vec%0d_valid", i-1), valid1, 1);
        check_val($sformatf("vec%0d_imm", i-1), imm1, v_imm1[i-1]);
        check_val($sformatf("vec%0d_imm_ps0", i-1), imm0, v_imm0[i-1]);
        check_val($sformatf("vec%0d_fmt", i-1), fmt1, v_fmt[i-1]);
        check_val($sformatf("vec%0d_ill", i-1), ill1, v_ill[i-1]);
        check_val($sformatf("vec%0d_tag", i-1), tag1, i-1);
      end
      if (i < N) begin
        valid = 1'b1; instr = v_instr[i]; tag = 8'(i);
      end else begin
        valid = 1'b0;
      end
    end
    @(negedge clk);
    check_val("stream_drained", valid1, 0);
    check_val("stream_cnt", cnt1, 2);

    // Backpressure: three offers, two fit, then release.
    dn_ready = 1'b0; valid = 1'b1; instr = 32'h800000B7; tag = 8'h21;
    check_val("bp_ready0", ready1, 1);
    @(negedge clk);
    check_val("bp_a_valid", valid1, 1);
    check_val("bp_a_tag", tag1, 8'h21);
    check_val("bp_ready1", ready1, 1);
    instr = 32'h43F0D093; tag = 8'h22;
    @(negedge clk);
    check_val("bp_full_ready", ready1, 0);
    check_val("bp_hold_tag", tag1, 8'h21);
    check_val("bp_hold_imm", imm1, 64'hFFFFFFFF80000000);
    instr = 32'hFE112C23; tag = 8'h23;
    @(negedge clk);
    check_val("bp_full_ready2", ready1, 0);
    check_val("bp_hold_tag2", tag1, 8'h21);
    check_val("bp_hold_imm2", imm1, 64'hFFFFFFFF80000000);
    dn_ready = 1'b1;
    @(negedge clk);
    check_val("bp_b_valid", valid1, 1);
    check_val("bp_b_tag", tag1, 8'h22);
    check_val("bp_b_imm", imm1, 64'h3F);
    check_val("bp_ready_back", ready1, 1);
    @(negedge clk);
    check_val("bp_c_valid", valid1, 1);
    check_val("bp_c_tag", tag1, 8'h23);
    check_val("bp_c_imm", imm1, 64'hFFFFFFFFFFFFFFF8);
    valid = 1'b0;
    @(negedge clk);
    check_val("bp_drained", valid1, 0);

    // Flush with both entries full plus a same-cycle offer.
    dn_ready = 1'b0; valid = 1'b1; instr = 32'hFFF00093; tag = 8'h51;
    @(negedge clk);
    instr = 32'h43F0D093; tag = 8'h52;
    @(negedge clk);
    check_val("fl_full_ready", ready1, 0);
    flush = 1'b1; instr = 32'h00000000; tag = 8'h53;
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    check_val("fl_valid", valid1, 0);
    check_val("fl_ready", ready1, 1);
    dn_ready = 1'b1;
    @(negedge clk);
    check_val("fl_no_ghost", valid1, 0);
    // Flush with an acceptable offer: dropped and not counted.
    valid = 1'b1; flush = 1'b1; instr = 32'h00000000; tag = 8'h54;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    check_val("fl2_valid", valid1, 0);
    check_val("fl2_cnt", cnt1, 2);
    @(negedge clk);
    check_val("fl2_no_ghost", valid1, 0);

    // Illegal counter saturation.
    valid = 1'b1; instr = 32'h00000000; tag = 8'h60;
    repeat (65532) @(posedge clk);
    @(negedge clk);
    check_val("cnt_fffe", cnt1, 16'hFFFE);
    check_val("cnt_ill_out", ill1, 1);
    check_val("cnt_fmt_out", fmt1, 6);
    @(negedge clk);
    check_val("cnt_ffff", cnt1, 16'hFFFF);
    repeat (2) @(negedge clk);
    valid = 1'b0;
    check_val("cnt_sat", cnt1, 16'hFFFF);
    check_val("cnt_sat_ps0", cnt0, 16'hFFFF);

    // Asynchronous reset mid-stall.
    @(negedge clk);
    dn_ready = 1'b0; valid = 1'b1; instr = 32'h800000B7; tag = 8'h71;
    @(negedge clk);
    instr = 32'hFFF00093; tag = 8'h72;
    @(negedge clk);
    valid = 1'b0;
    check_val("ar_pre_ready", ready1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("ar_valid", valid1, 0);
    check_val("ar_ready", ready1, 1);
    check_val("ar_cnt", cnt1, 0);
    check_val("ar_imm", imm1, 0);
    @(negedge clk);
    rst_n = 1'b1; dn_ready = 1'b1;
    @(negedge clk);
    check_val("ar_no_pulse", valid1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It takes one 32-bit RV instruction per handshake and produces its XLEN-wide immediate, a format code and an illegal-encoding flag. A 2-entry elastic buffer decouples it from backpressure downstream. It adds RV64 shamt/W-op support, optional pre-shifting of branch/jump offsets, a sideband tag, flush, and a saturating illegal-instruction counter.

## Interface
- `XLEN`, 64: immediate width; legal values are 32 and 64.
- `PRESHIFT`, 1: 1 = B/J offsets are output as byte offsets (bit0 = 0); 0 = raw halfword-unit offsets, with the shift done in the control unit.
- `TAG_W`, 8: width of the opaque sideband tag (PC low bits or ROB id).
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  input instruction valid.
- `o_ready`  out  1  block can accept input; registered.
- `i_instr`  in  32  instruction word.
- `i_tag`  in  TAG_W  sideband tag, carried unchanged.
- `i_flush`  in  1  synchronous flush of all buffered entries.
- `o_valid`  out  1  output entry valid.
- `i_ready`  in  1  downstream accepts the output.
- `o_imm`  out  XLEN  extended immediate.
- `o_fmt`  out  3  format: 0 I, 1 SHAMT, 2 S, 3 B, 4 U, 5 J, 6 NONE.
- `o_illegal`  out  1  the opcode is not recognised.
- `o_tag`  out  TAG_W  tag of the output entry.
- `o_illegal_cnt`  out  16  count of accepted illegal instructions; saturates at 0xFFFF.

## Operation
- Input transfer: `i_valid && o_ready`. Output transfer: `o_valid && i_ready`.
- Decode is combinational on `i_instr` and is registered into the buffer.
- Opcode → format and immediate. "Sext" means sign-extended to XLEN.
  - 0010011 and 0011011: f3 = 001 or 101 → SHAMT, with the shamt zero-extended.
    - Shamt is `instr[25:20]` for XLEN=64 with opcode 0010011.
    - Shamt is `instr[24:20]` otherwise.
  - 0010011 and 0011011, any other f3 → I, sext `instr[31:20]`.
  - 0000011, 1100111, 0001111 → I, sext `instr[31:20]`. All load widths are sign-extended, including LBU/LHU/LWU.
  - 0100011 → S, sext `{instr[31:25], instr[11:7]}`.
  - 1100011 → B. 13-bit offset `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`, sext.
    - If PRESHIFT=0, the offset is arithmetically right-shifted by 1.
  - 1101111 → J. 21-bit offset `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`, sext, with the same PRESHIFT rule.
  - 0110111, 0010111 → U, sext `{instr[31:12], 12'b0}`.
  - 0110011, 0111011, 1110011 → NONE, imm 0, not illegal.
  - Anything else, including `instr[1:0] != 11` → NONE, imm 0, `o_illegal` = 1.
- Buffer: a main register (drives the outputs) plus a skid register.
  - Input accepted while main is empty, or main is transferring out → goes to main.
  - Input accepted while main holds and is stalled → goes to skid.
  - When main transfers out and skid is full, skid moves to main and skid empties.
  - `o_ready` is the registered value of "skid empty at the next edge".
- `o_illegal_cnt` increments on every accepted input whose decode is illegal. Flush does not clear it; only reset does.

## Timing
- Latency: 1 cycle from input transfer to `o_valid` when unstalled. Throughput is 1 per cycle.
- Output stability: `o_imm`/`o_fmt`/`o_illegal`/`o_tag` are held stable while `o_valid && !i_ready`.
- Reset values (async assertion; synchronous-safe release):
  - `o_valid` = 0, `o_ready` = 1.
  - `o_imm`, `o_fmt`, `o_tag`, `o_illegal` = 0.
  - `o_illegal_cnt` = 0.
  - Skid is empty.
- Full: with main and skid both occupied, `o_ready` = 0. Inputs are ignored and `i_instr` is don't-care.
- Simultaneous output transfer and input transfer with skid empty: main is reloaded with the new input and `o_valid` stays 1.
- `i_flush`: at the next edge, both entries are invalidated and `o_ready` = 1.
  - A same-cycle input is dropped and is not counted.
  - A same-cycle output transfer still counts as delivered downstream.
- Reset mid-stream: all buffered entries are lost with no output pulse.
- Counter: at 0xFFFF, further illegal inputs leave it at 0xFFFF.

## Test plan
- XLEN=64, PRESHIFT=1, `i_ready`=1:
  - 0xFFF00093 → next cycle `o_imm`=0xFFFFFFFFFFFFFFFF, fmt 0.
  - 0x43F0D093 → `o_imm`=0x3F, fmt 1.
  - 0x800000B7 → `o_imm`=0xFFFFFFFF80000000, fmt 4.
- B offset, 0xFE000EE3:
  - PRESHIFT=1 → `o_imm`=0xFFFFFFFFFFFFFFFC, fmt 3.
  - PRESHIFT=0 → `o_imm`=0xFFFFFFFFFFFFFFFE.
- Backpressure:
  - Hold `i_ready`=0 and offer 3 back-to-back inputs. Only 2 are accepted and `o_ready` goes low after the second.
  - Release `i_ready`. Outputs come out in order on consecutive cycles and the third input is accepted.
- Flush with both entries full:
  - Assert `i_flush` for 1 cycle → `o_valid`=0 and `o_ready`=1 the next cycle.
  - A same-cycle `i_valid` instruction never appears at the output.
- Illegal input 0x00000000 → `o_illegal`=1, fmt 6, imm 0, counter 1. After force-loading the counter to 0xFFFF, a further illegal input leaves it at 0xFFFF.
- Assert `i_rst_n`=0 mid-stall, asynchronously → `o_valid`=0 and `o_ready`=1 immediately, without waiting for a clock edge.
